// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester/response channel bundle for the two-port ALU arbiter
//
// Carries both request channels (valid/ready/op/a/b) and both response
// channels (valid/ready/y/z/err).
//   master : requester side (drives requests and response ready)
//   slave  : arbiter side (drives request ready and responses)
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_y;
    logic             rsp0_z;
    logic             rsp0_err;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_y;
    logic             rsp1_z;
    logic             rsp1_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_y, rsp0_z, rsp0_err,
        input  rsp1_valid, rsp1_y, rsp1_z, rsp1_err,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_y, rsp0_z, rsp0_err,
        output rsp1_valid, rsp1_y, rsp1_z, rsp1_err,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter/sequencer for the shared registered ALU
//
// Grants one requester at a time, drives the ALU inputs, waits out the ALU
// latency, captures the result plus a locally computed zero flag, and returns
// them on the winner's response channel.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request channels 0/1 and response channels 0/1
//   alu_op/alu_a/alu_b: registered ALU inputs, held while idle
//   alu_y             : ALU result, valid ALU_LAT cycles after the inputs
// Optional feature: define ALU_ARB_OPCHECK_EN to reject opcode 111 with an
// error response instead of issuing it to the ALU.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y
);
    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;       // last-served port
    logic             owner_q, owner_d;   // port that owns the in-flight op
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;

    logic             grant0, grant1, accept, sel, rsp_ack, is_illegal;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    // ptr_q == 1 means port 1 was served last, so port 0 wins a tie.
    always_comb begin
        grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || ptr_q);
        grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !ptr_q);
        accept = grant0 || grant1;
        sel    = grant1;
        sel_op = sel ? bus.req1_op : bus.req0_op;
        sel_a  = sel ? bus.req1_a  : bus.req0_a;
        sel_b  = sel ? bus.req1_b  : bus.req0_b;
        rsp_ack = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
`ifdef ALU_ARB_OPCHECK_EN
        is_illegal = (sel_op == 3'b111);
`else
        is_illegal = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_y_d      = rsp_y_q;
        rsp_z_d      = rsp_z_q;
        rsp_err_d    = rsp_err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d   = sel;
                    owner_d = sel;
                    if (is_illegal) begin
                        // Rejected op skips the ALU entirely; inputs stay as they were.
                        rsp_y_d      = '0;
                        rsp_z_d      = 1'b0;
                        rsp_err_d    = 1'b1;
                        rsp0_valid_d = !sel;
                        rsp1_valid_d = sel;
                        state_d      = RESP;
                    end else begin
                        alu_op_d = sel_op;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        cnt_d    = CW'(ALU_LAT);
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                // EXEC lasts ALU_LAT+1 cycles: one for the ALU to sample, ALU_LAT for its result.
                if (cnt_q == '0) begin
                    rsp_y_d      = alu_y;
                    rsp_z_d      = (alu_y == '0);
                    rsp_err_d    = 1'b0;
                    rsp0_valid_d = !owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ack) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            alu_op_q     <= 3'b000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_y_q      <= '0;
            rsp_z_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_y_q      <= rsp_y_d;
            rsp_z_q      <= rsp_z_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_y     = rsp_y_q;
    assign bus.rsp1_y     = rsp_y_q;
    assign bus.rsp0_z     = rsp_z_q;
    assign bus.rsp1_z     = rsp_z_q;
    assign bus.rsp0_err   = rsp_err_q;
    assign bus.rsp1_err   = rsp_err_q;
    assign alu_op         = alu_op_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a transaction-level model
module tb_alu_arbiter;
`ifdef ALU_ARB_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_y = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    alu_arbiter_if #(.WIDTH(16)) bus ();

    alu_arbiter #(.WIDTH(16), .ALU_LAT(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .alu_op (alu_op),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_y  (alu_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a >> 1;
            3'd3:    return a << 1;
            3'd4:    return ~(a & b);
            3'd5:    return a | b;
            3'd6:    return a;
            default: return a ^ b;
        endcase
    endfunction

    // Single-cycle registered ALU model feeding the arbiter.
    always @(posedge clk) alu_y <= alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Transaction-level reference: one op in flight, response due a fixed
    // number of cycles after acceptance, round-robin from the last served port.
    bit          busy, was_busy, prev_rst, exp_err, exp_z;
    int          last, owner, due, g;
    logic [15:0] exp_y, m_a, m_b;
    logic [2:0]  m_op, a_op;
    logic [15:0] a_a, a_b;
    logic [1:0]  rdy, vld, exp_rdy;

    initial begin
        busy = 0; last = 1; owner = 0; due = 0; prev_rst = 1;
        m_op = '0; m_a = '0; m_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; last = 1; prev_rst = 1;
                m_op = '0; m_a = '0; m_b = '0;
            end else begin
                if (prev_rst) begin
                    check("reset_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
                    check("reset_rsp_y", {bus.rsp1_y, bus.rsp0_y}, 32'h0);
                    check("reset_rsp_z_err", {bus.rsp1_z, bus.rsp0_z, bus.rsp1_err, bus.rsp0_err}, 4'h0);
                end
                prev_rst = 0;
                rdy = {bus.req1_ready, bus.req0_ready};
                vld = {bus.req1_valid, bus.req0_valid};
                if (busy)                exp_rdy = 2'b00;
                else if (vld == 2'b11)   exp_rdy = (last == 1) ? 2'b01 : 2'b10;
                else                     exp_rdy = vld;
                check("req_ready", rdy, exp_rdy);
                check("alu_op", alu_op, m_op);
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                was_busy = busy;
                if (busy && cyc >= due) begin
                    check("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, (owner == 1) ? 2'b10 : 2'b01);
                    check("rsp_y", (owner == 1) ? bus.rsp1_y : bus.rsp0_y, exp_y);
                    check("rsp_z", (owner == 1) ? bus.rsp1_z : bus.rsp0_z, exp_z);
                    check("rsp_err", (owner == 1) ? bus.rsp1_err : bus.rsp0_err, exp_err);
                    if ((owner == 1) ? bus.rsp1_ready : bus.rsp0_ready) busy = 0;
                end else begin
                    check("rsp_valid_quiet", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
                end
                if (!was_busy && (rdy & vld) != 2'b00) begin
                    g = rdy[1] ? 1 : 0;
                    a_op = g ? bus.req1_op : bus.req0_op;
                    a_a  = g ? bus.req1_a  : bus.req0_a;
                    a_b  = g ? bus.req1_b  : bus.req0_b;
                    owner = g;
                    last  = g;
                    busy  = 1;
                    exp_err = OPCHECK && (a_op == 3'b111);
                    if (exp_err) begin
                        exp_y = '0; exp_z = 0; due = cyc + 1;
                    end else begin
                        exp_y = alu_fn(a_op, a_a, a_b);
                        exp_z = (exp_y == 16'h0);
                        due   = cyc + 3;
                        m_op = a_op; m_a = a_a; m_b = a_b;
                    end
                end
            end
        end
    end

    task automatic send(input int port, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit got = 0;
        if (port == 0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
        end
        if (!got) begin
            $display("FAIL send_timeout: port %0d not accepted within 50 cycles", port);
            $fatal(1);
        end
        @(posedge clk); #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    // One cycle of free-running traffic; a pending request is never withdrawn or altered.
    task automatic step(input bit rnd_valid, input int p0, input int p1);
        bit a0, a1;
        @(negedge clk);
        a0 = bus.req0_valid && bus.req0_ready;
        a1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk); #1;
        if (!bus.req0_valid || a0) begin
            bus.req0_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.req0_op = 3'($urandom_range(0, 7));
            bus.req0_a  = 16'($urandom);
            bus.req0_b  = 16'($urandom);
        end
        if (!bus.req1_valid || a1) begin
            bus.req1_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.req1_op = 3'($urandom_range(0, 7));
            bus.req1_a  = 16'($urandom);
            bus.req1_b  = 16'($urandom);
        end
        bus.rsp0_ready = (int'($urandom_range(0, 99)) < p0);
        bus.rsp1_ready = (int'($urandom_range(0, 99)) < p1);
    endtask

    task automatic drain(input int n);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(0, 3'b000, 16'd5, 16'd7);
        drain(6);
        send(1, 3'b001, 16'h1234, 16'h1234);
        drain(6);

        repeat (32) step(1'b0, 100, 100);
        drain(6);

        repeat (14) step(1'b0, 0, 100);
        repeat (14) step(1'b0, 100, 100);
        drain(6);

        send(0, 3'b000, 16'd3, 16'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drain(5);
        send(1, 3'b000, 16'd100, 16'd200);
        drain(6);

        send(0, 3'b111, 16'h00ff, 16'h0f0f);
        drain(6);

        repeat (400) step(1'b1, 70, 70);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
